// File: rtl/kd_internal_node_tree.sv
// Depth-6 k-d tree walker: 63 internal nodes held per level, one patch per clock,
// leaf number of each traversal presented six cycles after the patch is sampled.
module kd_internal_node_tree #(
  parameter int INTERNAL_WIDTH = 22,
  parameter int PATCH_WIDTH    = 55,
  parameter int ADDRESS_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fsm_enable,
  input  logic                      sender_enable,
  input  logic [INTERNAL_WIDTH-1:0] sender_data,
  input  logic                      patch_en,
  input  logic [PATCH_WIDTH-1:0]    patch_in,
  output logic [ADDRESS_WIDTH-1:0]  leaf_index,
  output logic                      receiver_en
);

  localparam int CW     = 11;
  localparam int LEVELS = 6;

  // Valid semantics: patch_en qualifies patch_in on the edge it is sampled; the
  // valid bit then rides the pipeline and surfaces as a single-cycle receiver_en.
  // There is no ready: the pipeline never stalls.

  logic [6:0]             wptr;
  logic                   load;
  logic                   valid_s [LEVELS];
  logic [PATCH_WIDTH-1:0] patch_s [LEVELS];
  logic [4:0]             pos_s   [1:LEVELS-1];
  logic [LEVELS-1:0]      dec;
  logic [5:0]             leaf_next;

  assign load      = fsm_enable && sender_enable && (wptr != 7'd63);
  assign leaf_next = {pos_s[LEVELS-1], dec[LEVELS-1]};

  function automatic logic signed [CW-1:0] comp_sel(input logic [PATCH_WIDTH-1:0] p,
                                                    input logic [CW-1:0] d);
    case (d)
      11'd0:   comp_sel = p[PATCH_WIDTH-1        -: CW];
      11'd1:   comp_sel = p[PATCH_WIDTH-1 - CW   -: CW];
      11'd2:   comp_sel = p[PATCH_WIDTH-1 - 2*CW -: CW];
      11'd3:   comp_sel = p[PATCH_WIDTH-1 - 3*CW -: CW];
      default: comp_sel = p[PATCH_WIDTH-1 - 4*CW -: CW];
    endcase
  endfunction

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int BASE = (1 << l) - 1;
    localparam int SIZE = 1 << l;

    logic [INTERNAL_WIDTH-1:0] node_rd;
    logic [CW-1:0]             dim;
    logic signed [CW-1:0]      median;
    logic signed [CW-1:0]      comp;

    if (l == 0) begin : g_root
      logic [INTERNAL_WIDTH-1:0] root;
      always_ff @(posedge clk) begin
        if (load && wptr == 7'd0) root <= sender_data;
      end
      assign node_rd = root;
    end else begin : g_mem
      logic [INTERNAL_WIDTH-1:0] mem [SIZE];
      logic [l-1:0]              off;
      assign off = l'(wptr - 7'(BASE));
      always_ff @(posedge clk) begin
        if (load && wptr >= 7'(BASE) && wptr < 7'(BASE + SIZE)) mem[off] <= sender_data;
      end
      // Position within this level is the path so far, MSB = root decision.
      assign node_rd = mem[pos_s[l][l-1:0]];
    end

    assign dim    = node_rd[CW-1:0];
    assign median = node_rd[2*CW-1:CW];
    assign comp   = comp_sel(patch_s[l], dim);
    assign dec[l] = !(comp < median);
  end

  always_ff @(posedge clk) begin
    patch_s[0] <= patch_in;
    for (int l = 1; l < LEVELS; l++) patch_s[l] <= patch_s[l-1];
    pos_s[1] <= 5'(dec[0]);
    for (int l = 2; l < LEVELS; l++) pos_s[l] <= {pos_s[l-1][3:0], dec[l-1]};

    if (rst_n) begin
      wptr        <= 7'd0;
      receiver_en <= 1'b0;
      leaf_index  <= '0;
      for (int l = 0; l < LEVELS; l++) valid_s[l] <= 1'b0;
    end else begin
      if (load) wptr <= wptr + 7'd1;
      valid_s[0] <= patch_en;
      for (int l = 1; l < LEVELS; l++) valid_s[l] <= valid_s[l-1];
      receiver_en <= valid_s[LEVELS-1];
      if (valid_s[LEVELS-1]) leaf_index <= ADDRESS_WIDTH'(leaf_next);
    end
  end

endmodule

// File: tb/tb_kd_internal_node_tree.sv
// Directed bench for kd_internal_node_tree: hand-built trees, hand-traced leaves.
module tb_kd_internal_node_tree;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fsm_enable;
  logic        sender_enable;
  logic [21:0] sender_data;
  logic        patch_en;
  logic [54:0] patch_in;
  logic [7:0]  leaf_index;
  logic        receiver_en;

  int vectors     = 0;
  int miscompares = 0;

  logic [54:0] pat      [8];
  logic [7:0]  exp_leaf [8];
  int          npat;
  logic        obs_en   [16];
  logic [7:0]  obs_leaf [16];

  kd_internal_node_tree dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fsm_enable    (fsm_enable),
    .sender_enable (sender_enable),
    .sender_data   (sender_data),
    .patch_en      (patch_en),
    .patch_in      (patch_in),
    .leaf_index    (leaf_index),
    .receiver_en   (receiver_en)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] mk_node(input int med, input int dim);
    mk_node = {med[10:0], dim[10:0]};
  endfunction

  function automatic logic [54:0] mk_patch(input int c0, input int c1, input int c2,
                                           input int c3, input int c4);
    mk_patch = {c0[10:0], c1[10:0], c2[10:0], c3[10:0], c4[10:0]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b1; fsm_enable = 1'b0; sender_enable = 1'b0; patch_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic load_word(input int med, input int dim);
    fsm_enable    = 1'b1;
    sender_enable = 1'b1;
    sender_data   = mk_node(med, dim);
    @(negedge clk);
    sender_enable = 1'b0;
  endtask

  // Tree where node n splits on dim n%5 at median 0.
  task automatic load_mod5(input int first, input int count);
    for (int n = first; n < first + count; n++) load_word(0, n % 5);
  endtask

  // Drives pat[0..npat-1] on consecutive cycles; obs[t] is sampled after the
  // t-th edge counted from the edge that samples pat[0].
  task automatic issue_stream();
    for (int t = 0; t < 16; t++) begin
      if (t < npat) begin
        patch_en = 1'b1;
        patch_in = pat[t];
      end else begin
        patch_en = 1'b0;
      end
      @(negedge clk);
      obs_en[t]   = receiver_en;
      obs_leaf[t] = leaf_index;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; fsm_enable = 1'b0; sender_enable = 1'b0;
    patch_en = 1'b1; patch_in = mk_patch(1, 2, 3, 4, 5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors += 2;
      if (receiver_en !== 1'b0) begin
        miscompares++; $display("FAIL reset_strobe cyc=%0d got %b want 0", i, receiver_en);
      end
      if (leaf_index !== 8'd0) begin
        miscompares++; $display("FAIL reset_leaf cyc=%0d got %0d want 0", i, leaf_index);
      end
    end
    rst_n = 1'b0; patch_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (receiver_en !== 1'b0 || leaf_index !== 8'd0) begin
        miscompares++;
        $display("FAIL reset_quiet cyc=%0d got en=%b leaf=%0d want en=0 leaf=0", i, receiver_en, leaf_index);
      end
    end
  endtask

  task automatic test_all_left_right();
    logic exp_en;
    do_reset();
    for (int n = 0; n < 63; n++) load_word(0, 0);
    fsm_enable = 1'b0;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin npat = 1; pat[0] = mk_patch(-1, 0, 0, 0, 0); exp_leaf[0] = 8'd0; end
        1: begin npat = 1; pat[0] = mk_patch(0, -7, -7, -7, -7); exp_leaf[0] = 8'd63; end
        default: begin
          npat = 2;
          pat[0] = mk_patch(1023, 0, 0, 0, 0);  exp_leaf[0] = 8'd63;
          pat[1] = mk_patch(-1024, 0, 0, 0, 0); exp_leaf[1] = 8'd0;
        end
      endcase
      issue_stream();
      for (int t = 0; t < 16; t++) begin
        exp_en = (t >= 6 && t < 6 + npat);
        vectors++;
        if (obs_en[t] !== exp_en) begin
          miscompares++; $display("FAIL lr_strobe s=%0d t=%0d got %b want %b", s, t, obs_en[t], exp_en);
        end
        if (exp_en) begin
          vectors++;
          if (obs_leaf[t] !== exp_leaf[t-6]) begin
            miscompares++; $display("FAIL lr_leaf s=%0d t=%0d got %0d want %0d", s, t, obs_leaf[t], exp_leaf[t-6]);
          end
        end
      end
    end
  endtask

  task automatic test_dim_clamp();
    logic exp_en;
    do_reset();
    for (int n = 0; n < 63; n++) load_word(0, (n % 2 == 1) ? 7 : 2047);
    fsm_enable = 1'b0;
    npat = 2;
    pat[0] = mk_patch(5, 5, 5, 5, -1);   exp_leaf[0] = 8'd0;
    pat[1] = mk_patch(-5, -5, -5, -5, 0); exp_leaf[1] = 8'd63;
    issue_stream();
    for (int t = 0; t < 16; t++) begin
      exp_en = (t >= 6 && t < 6 + npat);
      vectors++;
      if (obs_en[t] !== exp_en) begin
        miscompares++; $display("FAIL clamp_strobe t=%0d got %b want %b", t, obs_en[t], exp_en);
      end
      if (exp_en) begin
        vectors++;
        if (obs_leaf[t] !== exp_leaf[t-6]) begin
          miscompares++; $display("FAIL clamp_leaf t=%0d got %0d want %0d", t, obs_leaf[t], exp_leaf[t-6]);
        end
      end
    end
  endtask

  task automatic test_mixed_path();
    logic exp_en;
    do_reset();
    for (int n = 0; n < 63; n++) load_word(0, 2);
    do_reset();
    load_word(100, 2);
    for (int n = 1; n < 63; n++) load_word(0, 2);
    fsm_enable = 1'b0;
    npat = 3;
    pat[0] = mk_patch(0, 0, 100, 0, 0); exp_leaf[0] = 8'd63;
    pat[1] = mk_patch(0, 0, 99, 0, 0);  exp_leaf[1] = 8'd31;
    pat[2] = mk_patch(0, 0, -5, 0, 0);  exp_leaf[2] = 8'd0;
    issue_stream();
    for (int t = 0; t < 16; t++) begin
      exp_en = (t >= 6 && t < 6 + npat);
      vectors++;
      if (obs_en[t] !== exp_en) begin
        miscompares++; $display("FAIL mixed_strobe t=%0d got %b want %b", t, obs_en[t], exp_en);
      end
      if (exp_en) begin
        vectors++;
        if (obs_leaf[t] !== exp_leaf[t-6]) begin
          miscompares++; $display("FAIL mixed_leaf t=%0d got %0d want %0d", t, obs_leaf[t], exp_leaf[t-6]);
        end
      end
    end
  endtask

  task automatic set_mod5_patches();
    npat = 4;
    pat[0] = mk_patch(0, 0, 0, 0, 0);      exp_leaf[0] = 8'd63;
    pat[1] = mk_patch(-1, -1, -1, -1, -1); exp_leaf[1] = 8'd0;
    pat[2] = mk_patch(3, -2, 4, -6, 1);    exp_leaf[2] = 8'd50;
    pat[3] = mk_patch(-3, 2, -4, 6, -1);   exp_leaf[3] = 8'd16;
  endtask

  task automatic test_back_to_back();
    logic exp_en;
    do_reset();
    load_mod5(0, 63);
    fsm_enable = 1'b0;
    set_mod5_patches();
    issue_stream();
    for (int t = 0; t < 16; t++) begin
      exp_en = (t >= 6 && t < 6 + npat);
      vectors++;
      if (obs_en[t] !== exp_en) begin
        miscompares++; $display("FAIL b2b_strobe t=%0d got %b want %b", t, obs_en[t], exp_en);
      end
      if (exp_en) begin
        vectors++;
        if (obs_leaf[t] !== exp_leaf[t-6]) begin
          miscompares++; $display("FAIL b2b_leaf t=%0d got %0d want %0d", t, obs_leaf[t], exp_leaf[t-6]);
        end
      end
    end
    vectors++;
    if (obs_leaf[15] !== 8'd16) begin
      miscompares++; $display("FAIL b2b_hold got %0d want 16", obs_leaf[15]);
    end
  endtask

  task automatic test_flush();
    patch_en = 1'b1; patch_in = mk_patch(0, 0, 0, 0, 0);
    @(negedge clk);
    patch_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (receiver_en !== 1'b0 || leaf_index !== 8'd0) begin
        miscompares++;
        $display("FAIL flush cyc=%0d got en=%b leaf=%0d want en=0 leaf=0", i, receiver_en, leaf_index);
      end
    end
  endtask

  task automatic test_overflow_freeze();
    logic exp_en;
    do_reset();
    load_mod5(0, 10);
    fsm_enable = 1'b0;
    sender_data = mk_node(-1000, 0);
    for (int i = 0; i < 4; i++) begin
      sender_enable = 1'b1;
      @(negedge clk);
    end
    sender_enable = 1'b0;
    load_mod5(10, 53);
    for (int i = 0; i < 7; i++) load_word(-1000, 0);
    fsm_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sender_enable = 1'b1;
      @(negedge clk);
    end
    sender_enable = 1'b0;
    set_mod5_patches();
    issue_stream();
    for (int t = 0; t < 16; t++) begin
      exp_en = (t >= 6 && t < 6 + npat);
      vectors++;
      if (obs_en[t] !== exp_en) begin
        miscompares++; $display("FAIL ovf_strobe t=%0d got %b want %b", t, obs_en[t], exp_en);
      end
      if (exp_en) begin
        vectors++;
        if (obs_leaf[t] !== exp_leaf[t-6]) begin
          miscompares++; $display("FAIL ovf_leaf t=%0d got %0d want %0d", t, obs_leaf[t], exp_leaf[t-6]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; fsm_enable = 1'b0; sender_enable = 1'b0;
    sender_data = '0; patch_en = 1'b0; patch_in = '0;
    test_reset();
    test_all_left_right();
    test_flush();
    test_dim_clamp();
    test_mixed_path();
    test_back_to_back();
    test_overflow_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
